// File: rtl/lfsr_comparator_if.sv
// Signal bundle between the switch inputs, the LFSR opponent core and the
// player-input conditioning logic.
interface lfsr_comparator_if;
   logic [8:0] sw;
   logic [9:0] lfsr;
   logic       agreater;

   modport master (output sw, input lfsr, input agreater);
   modport slave  (input sw, output lfsr, output agreater);
endinterface

// File: rtl/lfsr_comparator.sv
// Pseudo-random opponent: free-running 10-bit XNOR LFSR plus an unsigned
// magnitude compare that fires when the switch threshold exceeds the LFSR.
module lfsr_comparator (
   input  logic              clk,
   input  logic              reset,
   lfsr_comparator_if.slave  bus
);
   logic [9:0]  r_lfsr;
   logic        w_fb;
   logic [9:0]  w_a;
   logic [9:0]  w_b;
   logic [10:0] w_gt_pre;
   logic [10:1] w_eq_pre;

   // XNOR taps 10 and 7; all-ones is the lock-up state, never reached from 0.
   assign w_fb = ~(r_lfsr[9] ^ r_lfsr[6]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr <= '0;
      end else begin
         r_lfsr <= {r_lfsr[8:0], w_fb};
      end
   end

   assign w_a = {1'b0, bus.sw};
   assign w_b = r_lfsr;

   // Bit-serial compare from the MSB: greater is decided at the first
   // differing bit, provided all higher bits were equal.
   assign w_gt_pre[10] = 1'b0;
   assign w_eq_pre[10] = 1'b1;

   for (genvar i = 9; i >= 0; i--) begin : g_cmp
      assign w_gt_pre[i] = w_gt_pre[i+1] | (w_eq_pre[i+1] & w_a[i] & ~w_b[i]);
      if (i > 0) begin : g_eq
         assign w_eq_pre[i] = w_eq_pre[i+1] & ~(w_a[i] ^ w_b[i]);
      end
   end

   assign bus.lfsr     = r_lfsr;
   assign bus.agreater = w_gt_pre[0];
endmodule

// File: tb/tb_lfsr_comparator.sv
// Bench for lfsr_comparator: constant sequence tables plus a shift/XNOR
// arithmetic model and integer threshold compare, with randomized sw.
module tb_lfsr_comparator;
   logic clk = 1'b0;
   logic reset = 1'b1;

   lfsr_comparator_if bus ();

   lfsr_comparator dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int m_lfsr = 0;
   int seq_tab [11] = '{0, 1, 3, 7, 15, 31, 63, 127, 254, 508, 1016};

   // Next state: double modulo 1024, then add 1 when bits 9 and 6 agree.
   function automatic int model_next(input int v);
      int n;
      int b9;
      int b6;
      b9 = (v / 512) % 2;
      b6 = (v / 64) % 2;
      n = (v * 2) % 1024;
      if (b9 == b6) n = n + 1;
      return n;
   endfunction

   function automatic logic model_gt(input int s, input int l);
      return (s > l) ? 1'b1 : 1'b0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      m_lfsr = model_next(m_lfsr);
   endtask

   task automatic restart(input logic [8:0] s);
      reset = 1'b1;
      bus.sw = s;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_lfsr = 0;
   endtask

   task automatic test_reset();
      bus.sw = 9'd0;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.lfsr !== 10'd0) begin
         failures++;
         $display("FAIL reset_value lfsr=%0d expected=0", bus.lfsr);
      end
      checks++;
      if (bus.agreater !== 1'b0) begin
         failures++;
         $display("FAIL reset_agreater agreater=%0b expected=0", bus.agreater);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.lfsr !== 10'd0) begin
         failures++;
         $display("FAIL reset_hold lfsr=%0d expected=0", bus.lfsr);
      end
   endtask

   task automatic run_table(input string name, input logic [8:0] s);
      restart(s);
      for (int k = 0; k < 11; k++) begin
         checks++;
         if (bus.lfsr !== 10'(seq_tab[k])) begin
            failures++;
            $display("FAIL %s_lfsr[%0d] lfsr=%0d expected=%0d", name, k, bus.lfsr, seq_tab[k]);
         end
         checks++;
         if (bus.agreater !== model_gt(int'(s), seq_tab[k])) begin
            failures++;
            $display("FAIL %s_agreater[%0d] agreater=%0b expected=%0b", name, k,
                     bus.agreater, model_gt(int'(s), seq_tab[k]));
         end
         if (k < 10) step();
      end
   endtask

   task automatic test_sequence();
      run_table("seq_sw3", 9'd3);
   endtask

   task automatic test_rereset();
      repeat (20) step();
      run_table("rereset_sw7", 9'd7);
   endtask

   task automatic test_threshold15();
      run_table("thresh_sw15", 9'd15);
   endtask

   task automatic test_full_period();
      bit seen [1024];
      int ones;
      int v;
      ones = 0;
      foreach (seen[i]) seen[i] = 1'b0;
      restart(9'd511);
      for (int c = 0; c < 1023; c++) begin
         v = int'(bus.lfsr);
         checks++;
         if (v != m_lfsr) begin
            failures++;
            $display("FAIL period_lfsr[%0d] lfsr=%0d expected=%0d", c, v, m_lfsr);
         end
         checks++;
         if (v == 1023 || seen[v]) begin
            failures++;
            $display("FAIL period_distinct[%0d] lfsr=%0d repeated_or_lockup=1 expected=0", c, v);
         end
         seen[v] = 1'b1;
         if (bus.agreater === 1'b1) ones++;
         step();
      end
      checks++;
      if (bus.lfsr !== 10'd0) begin
         failures++;
         $display("FAIL period_wrap lfsr=%0d expected=0", bus.lfsr);
      end
      checks++;
      if (ones != 511) begin
         failures++;
         $display("FAIL period_press_count count=%0d expected=511", ones);
      end
   endtask

   task automatic test_random_sw();
      logic [8:0] s;
      restart(9'($urandom_range(0, 511)));
      repeat (37) step();
      for (int c = 0; c < 200; c++) begin
         for (int j = 0; j < 2; j++) begin
            case ($urandom_range(0, 3))
               0: s = 9'd0;
               1: s = 9'd511;
               default: s = 9'($urandom_range(0, 511));
            endcase
            bus.sw = s;
            #1;
            checks++;
            if (bus.agreater !== model_gt(int'(s), m_lfsr)) begin
               failures++;
               $display("FAIL random_agreater[%0d.%0d] sw=%0d lfsr=%0d agreater=%0b expected=%0b",
                        c, j, s, bus.lfsr, bus.agreater, model_gt(int'(s), m_lfsr));
            end
         end
         checks++;
         if (int'(bus.lfsr) != m_lfsr) begin
            failures++;
            $display("FAIL random_lfsr[%0d] lfsr=%0d expected=%0d", c, bus.lfsr, m_lfsr);
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      restart(9'd100);
      repeat (5) step();
      checks++;
      if (int'(bus.lfsr) != 31) begin
         failures++;
         $display("FAIL async_pre lfsr=%0d expected=31", bus.lfsr);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.lfsr !== 10'd0) begin
         failures++;
         $display("FAIL async_clear lfsr=%0d expected=0", bus.lfsr);
      end
      checks++;
      if (bus.agreater !== 1'b1) begin
         failures++;
         $display("FAIL async_agreater agreater=%0b expected=1", bus.agreater);
      end
      bus.sw = 9'd0;
      #1;
      checks++;
      if (bus.agreater !== 1'b0) begin
         failures++;
         $display("FAIL async_sw0 agreater=%0b expected=0", bus.agreater);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_lfsr = 0;
      step();
      checks++;
      if (bus.lfsr !== 10'd1) begin
         failures++;
         $display("FAIL async_first_edge lfsr=%0d expected=1", bus.lfsr);
      end
   endtask

   initial begin
      bus.sw = 9'd0;
      test_reset();
      test_sequence();
      test_rereset();
      test_threshold15();
      test_full_period();
      test_random_sw();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout simulation_time_exceeded=1 expected=0");
      $fatal(1, "timeout");
   end
endmodule
